// File: rtl/orient_hist_if.sv
// orient_hist_if
// Bundles the gradient sample stream feeding the orientation histogram and
// the histogram/dominant-orientation result stream leaving it.
//   valid_sob, mor, the   : gradient sample strobe, magnitude, bin index
//   hist_valid/ready      : readout beat handshake
//   hist_idx, hist_bin    : bin index and value of the current beat
//   hist_last             : marks the beat carrying bin 15
//   dom_valid/bin/mag     : one-cycle dominant-bin result
//   busy, drop_err        : status
// Modports: slave = histogram block, master = producer/consumer side.
interface orient_hist_if #(
  parameter int DW = 8,
  parameter int BW = 24
);
  logic          valid_sob;
  logic [DW-1:0] mor;
  logic [3:0]    the;
  logic          hist_valid;
  logic          hist_ready;
  logic [3:0]    hist_idx;
  logic [BW-1:0] hist_bin;
  logic          hist_last;
  logic          dom_valid;
  logic [3:0]    dom_bin;
  logic [BW-1:0] dom_mag;
  logic          busy;
  logic          drop_err;

  modport slave (
    input  valid_sob, mor, the, hist_ready,
    output hist_valid, hist_idx, hist_bin, hist_last,
           dom_valid, dom_bin, dom_mag, busy, drop_err
  );

  modport master (
    output valid_sob, mor, the, hist_ready,
    input  hist_valid, hist_idx, hist_bin, hist_last,
           dom_valid, dom_bin, dom_mag, busy, drop_err
  );
endinterface

// File: rtl/orient_hist.sv
// orient_hist
// Accumulates gradient magnitudes into 16 orientation bins over a frame of
// SAMPLES samples, scans the bins for the dominant orientation, then streams
// the 16 bins out over a valid/ready handshake before starting a new frame.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous, active-low reset
//   bus  : orient_hist_if.slave (sample input, readout, dominant result, status)
// Parameters: DW magnitude width, BW bin width, SAMPLES samples per frame.
// Build option: define ORIENT_HIST_SAT_EN to make bin updates saturate at
// 2^BW-1; by default bin updates wrap modulo 2^BW.
module orient_hist #(
  parameter int DW      = 8,
  parameter int BW      = 24,
  parameter int SAMPLES = 65536
) (
  input  logic          clk,
  input  logic          rst,
  orient_hist_if.slave  bus
);

  localparam int CW = $clog2(SAMPLES + 1);
  localparam logic [CW-1:0] FRAME_CNT = CW'(SAMPLES);

  typedef enum logic [1:0] {ACC, SCAN, DUMP} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [BW-1:0] r_bins [16];
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_scanIdx;
  logic [3:0]    r_maxBin;
  logic [BW-1:0] r_maxMag;
  logic [3:0]    r_dumpIdx;
  logic          r_domValid;
  logic [3:0]    r_domBin;
  logic [BW-1:0] r_domMag;
  logic          r_dropErr;

  logic          w_accept;
  logic [CW-1:0] w_cntNext;
  logic          w_frameDone;
  logic          w_scanDone;
  logic          w_handshake;
  logic          w_lastBeat;
  logic [BW:0]   w_sum;
  logic [BW-1:0] w_binNext;
  logic          w_greater;
  logic [3:0]    w_candBin;
  logic [BW-1:0] w_candMag;

  assign w_accept    = (r_state == ACC) && bus.valid_sob;
  assign w_cntNext   = r_cnt + 1'b1;
  assign w_frameDone = w_accept && (w_cntNext == FRAME_CNT);
  assign w_scanDone  = (r_state == SCAN) && (r_scanIdx == 4'd15);
  assign w_handshake = bus.hist_valid && bus.hist_ready;
  assign w_lastBeat  = w_handshake && (r_dumpIdx == 4'd15);

  // One extra bit on the sum exposes the carry for saturation.
  assign w_sum = {1'b0, r_bins[bus.the]} + {{(BW + 1 - DW){1'b0}}, bus.mor};

`ifdef ORIENT_HIST_SAT_EN
  assign w_binNext = w_sum[BW] ? {BW{1'b1}} : w_sum[BW-1:0];
`else
  assign w_binNext = w_sum[BW-1:0];
`endif

  // Strictly-greater keeps the earliest (lowest) index on ties.
  assign w_greater = r_bins[r_scanIdx] > r_maxMag;
  assign w_candBin = w_greater ? r_scanIdx : r_maxBin;
  assign w_candMag = w_greater ? r_bins[r_scanIdx] : r_maxMag;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ACC;
    else      r_state <= w_next;
  end

  // Next state plus the outputs that are pure functions of state.
  always_comb begin
    w_next         = r_state;
    bus.hist_valid = 1'b0;
    bus.hist_idx   = 4'd0;
    bus.hist_bin   = '0;
    bus.hist_last  = 1'b0;
    bus.busy       = 1'b1;
    case (r_state)
      ACC: begin
        bus.busy = 1'b0;
        if (w_frameDone) w_next = SCAN;
      end
      SCAN: begin
        if (w_scanDone) w_next = DUMP;
      end
      DUMP: begin
        bus.hist_valid = 1'b1;
        bus.hist_idx   = r_dumpIdx;
        bus.hist_bin   = r_bins[r_dumpIdx];
        bus.hist_last  = (r_dumpIdx == 4'd15);
        if (w_lastBeat) w_next = ACC;
      end
      default: w_next = ACC;
    endcase
  end

  // Bin accumulation, scan bookkeeping, readout pointer and status flags.
  // The running max restarts at zero so an empty histogram reports bin 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) r_bins[i] <= '0;
      r_cnt      <= '0;
      r_scanIdx  <= 4'd0;
      r_maxBin   <= 4'd0;
      r_maxMag   <= '0;
      r_dumpIdx  <= 4'd0;
      r_domValid <= 1'b0;
      r_domBin   <= 4'd0;
      r_domMag   <= '0;
      r_dropErr  <= 1'b0;
    end else begin
      r_domValid <= 1'b0;
      if (bus.valid_sob && (r_state != ACC)) r_dropErr <= 1'b1;
      if (w_accept) begin
        r_bins[bus.the] <= w_binNext;
        r_cnt           <= w_frameDone ? '0 : w_cntNext;
      end
      if (r_state == SCAN) begin
        r_scanIdx <= r_scanIdx + 4'd1;
        if (w_scanDone) begin
          r_domValid <= 1'b1;
          r_domBin   <= w_candBin;
          r_domMag   <= w_candMag;
          r_maxBin   <= 4'd0;
          r_maxMag   <= '0;
        end else begin
          r_maxBin <= w_candBin;
          r_maxMag <= w_candMag;
        end
      end
      if (w_handshake) begin
        r_dumpIdx <= r_dumpIdx + 4'd1;
        if (w_lastBeat) begin
          for (int i = 0; i < 16; i++) r_bins[i] <= '0;
        end
      end
    end
  end

  assign bus.dom_valid = r_domValid;
  assign bus.dom_bin   = r_domBin;
  assign bus.dom_mag   = r_domMag;
  assign bus.drop_err  = r_dropErr;

endmodule

// File: tb/tb_orient_hist.sv
// tb_orient_hist
// Directed bench for orient_hist using three instances: a 16-sample frame
// (readout stall, dropped sample, reset during a stalled readout), a
// 4-sample tie case, and an 8-bit-bin overflow case whose expectation
// depends on ORIENT_HIST_SAT_EN.
module tb_orient_hist;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   nAsserts = 0;
  int   nFail    = 0;

  always #5 clk = ~clk;

  orient_hist_if #(.DW(8), .BW(24)) ifA ();
  orient_hist_if #(.DW(8), .BW(24)) ifB ();
  orient_hist_if #(.DW(8), .BW(8))  ifC ();

  orient_hist #(.DW(8), .BW(24), .SAMPLES(16)) dutA (.clk(clk), .rst(rst), .bus(ifA.slave));
  orient_hist #(.DW(8), .BW(24), .SAMPLES(4))  dutB (.clk(clk), .rst(rst), .bus(ifB.slave));
  orient_hist #(.DW(8), .BW(8),  .SAMPLES(2))  dutC (.clk(clk), .rst(rst), .bus(ifC.slave));

  // Advance to just after the next rising edge, where outputs are sampled
  // and inputs are changed.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nAsserts++;
    assert (observed === expected)
    else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one sample into instance A for a single cycle.
  task automatic applyStimulus(input logic [3:0] th, input logic [7:0] mg);
    ifA.valid_sob = 1'b1;
    ifA.the       = th;
    ifA.mor       = mg;
    tick();
    ifA.valid_sob = 1'b0;
  endtask

  initial begin
    int  beat;
    int  stall;
    logic found;

    ifA.valid_sob = 1'b0; ifA.mor = '0; ifA.the = '0; ifA.hist_ready = 1'b0;
    ifB.valid_sob = 1'b0; ifB.mor = '0; ifB.the = '0; ifB.hist_ready = 1'b1;
    ifC.valid_sob = 1'b0; ifC.mor = '0; ifC.the = '0; ifC.hist_ready = 1'b1;

    tick(); tick();
    checkOutput("rst_busy",     ifA.busy, 0);
    checkOutput("rst_hvalid",   ifA.hist_valid, 0);
    checkOutput("rst_domvalid", ifA.dom_valid, 0);
    checkOutput("rst_domMag",   ifA.dom_mag, 0);
    checkOutput("rst_dropErr",  ifA.drop_err, 0);
    rst = 1'b1;
    tick();

    // Frame 1: bin k receives k+1.
    for (int k = 0; k < 16; k++) applyStimulus(4'(k), 8'(k + 1));
    checkOutput("A_busyScan", ifA.busy, 1);
    checkOutput("A_dropPre",  ifA.drop_err, 0);
    applyStimulus(4'd0, 8'd50);
    checkOutput("A_dropSet", ifA.drop_err, 1);

    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (ifA.dom_valid) found = 1'b1;
      else tick();
    end
    checkOutput("A_domSeen", found, 1);
    checkOutput("A_domBin",  ifA.dom_bin, 15);
    checkOutput("A_domMag",  ifA.dom_mag, 16);
    checkOutput("A_dumpHv",  ifA.hist_valid, 1);
    tick();
    checkOutput("A_domPulse", ifA.dom_valid, 0);
    checkOutput("A_domHold",  ifA.dom_mag, 16);

    beat = 0;
    stall = 0;
    for (int c = 0; c < 60 && beat < 16; c++) begin
      checkOutput("A_beatHv",   ifA.hist_valid, 1);
      checkOutput("A_beatIdx",  ifA.hist_idx, beat);
      checkOutput("A_beatBin",  ifA.hist_bin, beat + 1);
      checkOutput("A_beatLast", ifA.hist_last, (beat == 15));
      if (beat == 2 && stall < 5) begin
        ifA.hist_ready = 1'b0;
        stall++;
      end else begin
        ifA.hist_ready = 1'b1;
      end
      tick();
      if (ifA.hist_ready) beat++;
    end
    ifA.hist_ready = 1'b0;
    checkOutput("A_beats",     beat, 16);
    checkOutput("A_stalls",    stall, 5);
    checkOutput("A_postHv",    ifA.hist_valid, 0);
    checkOutput("A_postBusy",  ifA.busy, 0);
    checkOutput("A_dropStick", ifA.drop_err, 1);

    // Frame 2: every bin gets 2, so the tie resolves to bin 0; the dropped
    // sample of frame 1 must not appear.
    for (int k = 0; k < 16; k++) applyStimulus(4'(k), 8'd2);
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (ifA.dom_valid) found = 1'b1;
      else tick();
    end
    checkOutput("A2_domSeen", found, 1);
    checkOutput("A2_domBin",  ifA.dom_bin, 0);
    checkOutput("A2_domMag",  ifA.dom_mag, 2);
    checkOutput("A2_bin0",    ifA.hist_bin, 2);
    tick(); tick(); tick();
    checkOutput("A2_stallIdx", ifA.hist_idx, 0);
    checkOutput("A2_stallHv",  ifA.hist_valid, 1);

    // Reset mid-cycle while the readout is stalled.
    #2;
    rst = 1'b0;
    #1;
    checkOutput("R_hvalid",  ifA.hist_valid, 0);
    checkOutput("R_busy",    ifA.busy, 0);
    checkOutput("R_dropErr", ifA.drop_err, 0);
    checkOutput("R_domBin",  ifA.dom_bin, 0);
    checkOutput("R_domMag",  ifA.dom_mag, 0);
    checkOutput("R_histIdx", ifA.hist_idx, 0);
    checkOutput("R_histBin", ifA.hist_bin, 0);
    checkOutput("R_histLast", ifA.hist_last, 0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // Frame 3: all samples to bin 4; stale bins would show 114.
    for (int k = 0; k < 16; k++) applyStimulus(4'd4, 8'd7);
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (ifA.dom_valid) found = 1'b1;
      else tick();
    end
    checkOutput("A3_domSeen", found, 1);
    checkOutput("A3_domBin",  ifA.dom_bin, 4);
    checkOutput("A3_domMag",  ifA.dom_mag, 112);
    ifA.hist_ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      tick();
      if (!ifA.busy) found = 1'b1;
    end
    checkOutput("A3_drained", found, 1);

    // Instance B: tie between bins 3 and 7.
    for (int k = 0; k < 4; k++) begin
      ifB.valid_sob = 1'b1;
      ifB.the       = (k < 2) ? 4'd3 : 4'd7;
      ifB.mor       = 8'd10;
      tick();
    end
    ifB.valid_sob = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (ifB.dom_valid) found = 1'b1;
      else tick();
    end
    checkOutput("B_domSeen", found, 1);
    checkOutput("B_domBin",  ifB.dom_bin, 3);
    checkOutput("B_domMag",  ifB.dom_mag, 20);

    // Instance C: 200 + 200 in an 8-bit bin.
    for (int k = 0; k < 2; k++) begin
      ifC.valid_sob = 1'b1;
      ifC.the       = 4'd0;
      ifC.mor       = 8'd200;
      tick();
    end
    ifC.valid_sob = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (ifC.dom_valid) found = 1'b1;
      else tick();
    end
    checkOutput("C_domSeen", found, 1);
    checkOutput("C_domBin",  ifC.dom_bin, 0);
`ifdef ORIENT_HIST_SAT_EN
    checkOutput("C_bin0", ifC.dom_mag, 255);
`else
    checkOutput("C_bin0", ifC.dom_mag, 144);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
